// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, issues single-outstanding
// word reads and hands instructions to decode over valid/ready.
//
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_pcsrc, i_nextPC     redirect request and target from execute
//   o_imem_req/addr       one-cycle read strobe and word address
//   i_imem_valid/rdata    read data return pulse and word
//   o_instr_valid         instruction bundle below is valid
//   i_instr_ready         decode accepts this cycle
//   o_instr/o_pc/o_pc_plus4 fetched word, its address, address+4
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pcsrc,
  input  logic [31:0] i_nextPC,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] target;

  assign target = {i_nextPC[31:2], 2'b00};

  // Request strobe is a pure state decode; the address is the PC register.
  assign o_imem_req  = (state == FETCH);
  assign o_imem_addr = pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      flush         <= 1'b0;
      o_instr_valid <= 1'b0;
      o_instr       <= NOP_INSTR;
      o_pc          <= RESET_PC;
      o_pc_plus4    <= RESET_PC + 32'd4;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          state <= WAIT;
          // The request is already out; mark its data as stale.
          if (i_pcsrc) begin
            pc    <= target;
            flush <= 1'b1;
          end
        end
        WAIT: begin
          if (i_imem_valid) begin
            if (flush || i_pcsrc) begin
              flush <= 1'b0;
              state <= FETCH;
              if (i_pcsrc) begin
                pc <= target;
              end
            end else begin
              o_instr       <= i_imem_rdata;
              o_pc          <= pc;
              o_pc_plus4    <= pc + 32'd4;
              pc            <= pc + 32'd4;
              o_instr_valid <= 1'b1;
              state         <= HOLD;
            end
          end else if (i_pcsrc) begin
            pc    <= target;
            flush <= 1'b1;
          end
        end
        HOLD: begin
          // A redirect without ready drops the held word.
          if (i_instr_ready || i_pcsrc) begin
            o_instr_valid <= 1'b0;
            o_instr       <= NOP_INSTR;
            state         <= FETCH;
            if (i_pcsrc) begin
              pc <= target;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random
// redirects, ready and memory latency against a transaction model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        i_clk;
  logic        i_rst;
  logic        i_pcsrc;
  logic [31:0] i_nextPC;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_valid;
  logic [31:0] i_imem_rdata;
  logic        o_instr_valid;
  logic        i_instr_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;

  fetch_unit #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pcsrc      (i_pcsrc),
    .i_nextPC     (i_nextPC),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_valid (i_imem_valid),
    .i_imem_rdata (i_imem_rdata),
    .o_instr_valid(o_instr_valid),
    .i_instr_ready(i_instr_ready),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .o_pc_plus4   (o_pc_plus4)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Protocol-level view: a request cycle, a request outstanding,
  // or an instruction being offered to decode.
  bit          m_req, m_wait, m_hold, m_stale;
  logic [31:0] m_pc, m_instr, m_ipc, req_addr;
  int          cnt;
  int          lat_cfg;
  bit          force_valid;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("imem_req", {31'b0, o_imem_req}, {31'b0, m_req});
    if (m_req) chk("imem_addr", o_imem_addr, m_pc);
    chk("instr_valid", {31'b0, o_instr_valid}, {31'b0, m_hold});
    if (m_hold) begin
      chk("instr", o_instr, m_instr);
      chk("pc", o_pc, m_ipc);
      chk("pc_plus4", o_pc_plus4, m_ipc + 32'd4);
    end else begin
      chk("instr_nop", o_instr, NOP);
    end
  endtask

  task automatic tick(input bit pcsrc, input logic [31:0] tgt,
                      input bit ready);
    logic [31:0] t;
    bit v;
    t = {tgt[31:2], 2'b00};
    v = 1'b0;
    if (m_wait) begin
      cnt--;
      v = (cnt <= 0);
    end
    if (force_valid) v = 1'b1;
    i_pcsrc       = pcsrc;
    i_nextPC      = tgt;
    i_instr_ready = ready;
    i_imem_valid  = v;
    i_imem_rdata  = v ? memword(req_addr) : $urandom;
    if (m_req) begin
      req_addr = m_pc;
      cnt      = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
      m_req    = 1'b0;
      m_wait   = 1'b1;
      if (pcsrc) begin
        m_pc    = t;
        m_stale = 1'b1;
      end
    end else if (m_wait) begin
      if (v) begin
        m_wait = 1'b0;
        if (m_stale || pcsrc) begin
          m_stale = 1'b0;
          if (pcsrc) m_pc = t;
          m_req = 1'b1;
        end else begin
          m_instr = memword(req_addr);
          m_ipc   = req_addr;
          m_pc    = req_addr + 32'd4;
          m_hold  = 1'b1;
        end
      end else if (pcsrc) begin
        m_pc    = t;
        m_stale = 1'b1;
      end
    end else if (m_hold) begin
      if (ready || pcsrc) begin
        m_hold = 1'b0;
        m_req  = 1'b1;
        if (pcsrc) m_pc = t;
      end
    end else begin
      m_req = 1'b1;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    check_outputs();
  endtask

  task automatic do_reset(input bit late_valid);
    i_rst        = 1'b1;
    i_imem_valid = late_valid;
    i_pcsrc      = 1'b0;
    #1;
    chk("rst_req", {31'b0, o_imem_req}, 32'd0);
    chk("rst_valid", {31'b0, o_instr_valid}, 32'd0);
    chk("rst_instr", o_instr, NOP);
    chk("rst_pc", o_pc, RST_PC);
    chk("rst_pc4", o_pc_plus4, RST_PC + 32'd4);
    m_req   = 1'b0;
    m_wait  = 1'b0;
    m_hold  = 1'b0;
    m_stale = 1'b0;
    m_pc    = RST_PC;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    force_valid = late_valid;
    tick(1'b0, 32'h0, 1'b1);
    force_valid = 1'b0;
  endtask

  task automatic to_req(input bit ready);
    for (int k = 0; k < 12 && !m_req; k++) tick(1'b0, 32'h0, ready);
    chk("reach_req", {31'b0, o_imem_req}, 32'd1);
  endtask

  task automatic to_hold();
    for (int k = 0; k < 16 && !m_hold; k++) tick(1'b0, 32'h0, 1'b0);
    chk("reach_hold", {31'b0, o_instr_valid}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst         = 1'b1;
    i_pcsrc       = 1'b0;
    i_nextPC      = 32'h0;
    i_imem_valid  = 1'b0;
    i_imem_rdata  = 32'h0;
    i_instr_ready = 1'b0;
    force_valid   = 1'b0;
    lat_cfg       = 1;
    @(negedge i_clk);
    do_reset(1'b0);

    // Sequential stream, latency 1, decode always ready.
    repeat (9) tick(1'b0, 32'h0, 1'b1);

    // Decode stalls five cycles in HOLD.
    to_hold();
    repeat (5) tick(1'b0, 32'h0, 1'b0);
    tick(1'b0, 32'h0, 1'b1);

    // Redirect in the request cycle with latency 3.
    lat_cfg = 3;
    to_req(1'b1);
    tick(1'b1, 32'h0000_0103, 1'b1);
    repeat (4) tick(1'b0, 32'h0, 1'b1);
    chk("redir_addr", o_imem_addr, 32'h0000_0100);
    repeat (6) tick(1'b0, 32'h0, 1'b1);

    // Redirect coincident with returned data.
    lat_cfg = 1;
    to_req(1'b1);
    tick(1'b0, 32'h0, 1'b1);
    tick(1'b1, 32'h0000_0200, 1'b1);
    chk("drop_addr", o_imem_addr, 32'h0000_0200);
    repeat (4) tick(1'b0, 32'h0, 1'b1);

    // Redirect together with accept in HOLD.
    to_hold();
    tick(1'b1, 32'h0000_0040, 1'b1);
    chk("hold_redir", o_imem_addr, 32'h0000_0040);
    repeat (3) tick(1'b0, 32'h0, 1'b1);

    // PC wrap at the top of the address space.
    to_req(1'b1);
    tick(1'b1, 32'hFFFF_FFFE, 1'b1);
    to_hold();
    chk("wrap_pc", o_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", o_pc_plus4, 32'h0);
    tick(1'b0, 32'h0, 1'b1);
    chk("wrap_addr", o_imem_addr, 32'h0);

    // Reset while a request is outstanding; late data ignored.
    lat_cfg = 3;
    to_req(1'b1);
    tick(1'b0, 32'h0, 1'b1);
    do_reset(1'b1);
    chk("post_rst_addr", o_imem_addr, RST_PC);
    repeat (6) tick(1'b0, 32'h0, 1'b1);

    // Random traffic.
    lat_cfg = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset(1'b1);
      tick(($urandom_range(0, 9) == 0), $urandom,
           ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
